// File: rtl/ram_arb_pkg.sv
// Shared types, constants and the round-robin search helper for ram_arbiter.
// Optional feature macro (used by the top): RAM_ARB_PERF_CNT_EN.
package ram_arb_pkg;

    // Arbitration FSM: free round-robin, or one requester owns the RAM
    typedef enum logic {
        ARB    = 1'b0,
        LOCKED = 1'b1
    } arb_state_e;

    localparam int PERF_CNT_WIDTH = 32;

    // Requester indices are carried at a fixed width covering the largest
    // supported configuration (8 requesters).
    localparam int MAX_REQ = 8;
    localparam int IDX_W   = 3;

    typedef struct packed {
        logic             found;
        logic [IDX_W-1:0] idx;
    } rr_pick_t;

    // First set bit of valid, searching upward from last+1 and wrapping at num_req
    function automatic rr_pick_t rr_pick(input logic [MAX_REQ-1:0] valid,
                                         input logic [IDX_W-1:0]   last,
                                         input int                 num_req);
        rr_pick_t res;
        int       cand;
        res = '0;
        for (int k = 1; k <= MAX_REQ; k++) begin
            cand = (int'(last) + k) % num_req;
            if (k <= num_req && !res.found && valid[cand[IDX_W-1:0]]) begin
                res.found = 1'b1;
                res.idx   = cand[IDX_W-1:0];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/ram_arbiter_rr_priority_picker.sv
// Combinational rotate/priority-encode used while the arbiter is in ARB.
module rr_priority_picker
    import ram_arb_pkg::*;
#(
    parameter int NUM_REQ = 2
) (
    input  logic [NUM_REQ-1:0] valid_i,
    input  logic [IDX_W-1:0]   last_i,
    output logic               found_o,
    output logic [IDX_W-1:0]   idx_o
);

    logic [MAX_REQ-1:0] valid_ext;
    rr_pick_t           pick;

    // Widen to the package search width and pick the next requester
    always_comb begin
        valid_ext = MAX_REQ'(valid_i);
        pick      = rr_pick(valid_ext, last_i, NUM_REQ);
        found_o   = pick.found;
        idx_o     = pick.idx;
    end

endmodule

// File: rtl/ram_arbiter.sv
// Round-robin arbiter sharing one single-port RAM among NUM_REQ requesters,
// with registered read data and an optional exclusive lock.
// Optional feature: define RAM_ARB_PERF_CNT_EN to add per-requester grant counters.
module ram_arbiter
    import ram_arb_pkg::*;
#(
    parameter int NUM_REQ    = 2,
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                          clk,
    input  logic                          rst,
`ifdef RAM_ARB_PERF_CNT_EN
    output logic [NUM_REQ*PERF_CNT_WIDTH-1:0] perf_grant_cnt,
`endif
    input  logic [NUM_REQ-1:0]            req_valid,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic [NUM_REQ-1:0]            req_we,
    input  logic [NUM_REQ-1:0]            req_lock,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
    output logic [NUM_REQ-1:0]            rsp_valid,
    output logic [DATA_WIDTH-1:0]         rsp_rdata,
    output logic [ADDR_WIDTH-1:0]         ram_addr,
    output logic [DATA_WIDTH-1:0]         ram_wr_data,
    output logic                          ram_wr_en,
    input  logic [DATA_WIDTH-1:0]         ram_rd_data
);

    arb_state_e             state_q, state_d;
    logic [IDX_W-1:0]       owner_q, owner_d;
    logic [IDX_W-1:0]       last_q, last_d;
    logic [NUM_REQ-1:0]     rsp_valid_q, rsp_valid_d;
    logic [DATA_WIDTH-1:0]  rsp_rdata_q, rsp_rdata_d;

    logic                   pick_found;
    logic [IDX_W-1:0]       pick_idx;
    logic                   found;
    logic [IDX_W-1:0]       winner;
    logic [NUM_REQ-1:0]     grant_oh;
    logic                   sel_we;
    logic                   sel_lock;

    rr_priority_picker #(.NUM_REQ(NUM_REQ)) u_picker (
        .valid_i (req_valid),
        .last_i  (last_q),
        .found_o (pick_found),
        .idx_o   (pick_idx)
    );

    // Winner selection: round-robin in ARB, only the owner while LOCKED
    always_comb begin
        winner = pick_idx;
        found  = pick_found;
        if (state_q == LOCKED) begin
            winner = owner_q;
            found  = 1'b0;
            for (int i = 0; i < NUM_REQ; i++) begin
                if (owner_q == IDX_W'(i)) found = req_valid[i];
            end
        end
    end

    // Grant vector and datapath mux; requester 0 drives the RAM when idle
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so no path leaves it unassigned (which would infer a latch).
        grant_oh    = '0;
        sel_we      = 1'b0;
        sel_lock    = 1'b0;
        ram_addr    = req_addr[ADDR_WIDTH-1:0];
        ram_wr_data = req_wdata[DATA_WIDTH-1:0];
        for (int i = 0; i < NUM_REQ; i++) begin
            if (found && winner == IDX_W'(i)) begin
                grant_oh[i] = 1'b1;
                sel_we      = req_we[i];
                sel_lock    = req_lock[i];
                ram_addr    = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                ram_wr_data = req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // A grant is only raised towards a valid requester, so found == handshake
    always_comb begin
        req_ready = grant_oh;
        ram_wr_en = found & sel_we;
        rsp_valid = rsp_valid_q;
        rsp_rdata = rsp_rdata_q;
    end

    // Next-state: pointer, lock FSM and one-cycle read response
    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        last_d      = last_q;
        rsp_valid_d = '0;
        rsp_rdata_d = rsp_rdata_q;
        if (found) begin
            last_d = winner;
            if (!sel_we) begin
                rsp_valid_d = grant_oh;
                rsp_rdata_d = ram_rd_data;
            end
            if (state_q == ARB && sel_lock) begin
                state_d = LOCKED;
                owner_d = winner;
            end else if (state_q == LOCKED && !sel_lock) begin
                state_d = ARB;
            end
        end
    end

    // State registers; reset wins over any handshake in the same cycle
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            state_q     <= ARB;
            owner_q     <= '0;
            last_q      <= IDX_W'(NUM_REQ - 1);
            rsp_valid_q <= '0;
            rsp_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            last_q      <= last_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

`ifdef RAM_ARB_PERF_CNT_EN
    logic [PERF_CNT_WIDTH-1:0] cnt_q [NUM_REQ];
    logic [PERF_CNT_WIDTH-1:0] cnt_d [NUM_REQ];

    // Saturating per-requester handshake counters
    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            cnt_d[i] = cnt_q[i];
            if (grant_oh[i] && cnt_q[i] != {PERF_CNT_WIDTH{1'b1}}) cnt_d[i] = cnt_q[i] + 1'b1;
        end
    end

    // Counter registers, cleared by reset
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_REQ; i++) begin
            if (rst) cnt_q[i] <= '0;
            else     cnt_q[i] <= cnt_d[i];
        end
    end

    // Flatten counters onto the output port, requester i in slice i
    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            perf_grant_cnt[i*PERF_CNT_WIDTH +: PERF_CNT_WIDTH] = cnt_q[i];
        end
    end
`endif

endmodule
